operand_fetch: RTL and testbench

Issue stage directly upstream of the 16-bit ALU. Accepts one 16-bit instruction per cycle over a valid/ready handshake, decodes it, reads an 8×16 register file with write-back bypass, and tracks outstanding destinations in a scoreboard. It presents registered operands, `alu_op` and destination info to the ALU. The register file is written through the write-back port driven by the downstream write-back stage.

---
 rtl/mips_pkg.sv | 44 ++++
 rtl/operand_fetch_if.sv | 32 +++
 rtl/regfile_2r1w.sv | 45 ++++
 rtl/operand_fetch.sv | 130 +++++++++++++
 tb/tb_operand_fetch.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants, decode struct and helpers for the issue stage
package mips_pkg;

    localparam int NREG = 8;
    localparam int W    = 16;
    localparam int AW   = 3;

    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_SGE = 3'b011;

    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_ADD  = 4'h1;
    localparam logic [3:0] OPC_SUB  = 4'h2;
    localparam logic [3:0] OPC_SGE  = 4'h3;
    localparam logic [3:0] OPC_ADDI = 4'h4;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS_MSB  = 8;
    localparam int RS_LSB  = 6;
    localparam int RT_MSB  = 5;
    localparam int RT_LSB  = 3;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;

    // Control bits derived from the opcode alone.
    typedef struct packed {
        logic [2:0] op;
        logic       we;
        logic       illegal;
        logic       use_imm;
        logic       use_rt;
    } decode_t;

    // imm6[5] replicated into the upper bits.
    function automatic logic [W-1:0] sext_imm6(input logic [5:0] imm);
        return {{(W-6){imm[5]}}, imm};
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - instruction, write-back and issue-bundle signals
interface operand_fetch_if;
    import mips_pkg::*;

    logic          in_valid;
    logic [W-1:0]  in_instr;
    logic          in_ready;

    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [W-1:0]  wb_data;

    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [2:0]    alu_op;
    logic [AW-1:0] rd_out;
    logic          we_out;
    logic          illegal;

    modport master (
        output in_valid, in_instr, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_op, rd_out, we_out, illegal
    );

    modport slave (
        input  in_valid, in_instr, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_op, rd_out, we_out, illegal
    );

endinterface

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 8x16 register file, two bypassed read ports, one write port
module regfile_2r1w
    import mips_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] i_ra_addr,
    input  logic [AW-1:0] i_rb_addr,
    output logic [W-1:0]  o_ra_data,
    output logic [W-1:0]  o_rb_data,
    input  logic          i_wb_en,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [W-1:0]  i_wb_data
);

    logic [W-1:0] r_regs [NREG];

    // Write port; R0 is never written so it stays at its reset value of zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wb_en && (i_wb_addr != '0)) begin
            r_regs[i_wb_addr] <= i_wb_data;
        end
    end

    // Read port A: R0 forced to zero, same-cycle write-back forwarded.
    always_comb begin
        o_ra_data = '0;
        if (i_ra_addr != '0) begin
            o_ra_data = (i_wb_en && (i_wb_addr == i_ra_addr)) ? i_wb_data : r_regs[i_ra_addr];
        end
    end

    // Read port B: same rules as port A.
    always_comb begin
        o_rb_data = '0;
        if (i_rb_addr != '0) begin
            o_rb_data = (i_wb_en && (i_wb_addr == i_rb_addr)) ? i_wb_data : r_regs[i_rb_addr];
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - decode, hazard scoreboard and registered issue bundle
module operand_fetch
    import mips_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    operand_fetch_if.slave  io_bus
);

    logic [3:0]      w_opcode;
    logic [AW-1:0]   w_rd;
    logic [AW-1:0]   w_rs;
    logic [AW-1:0]   w_rt;
    logic [5:0]      w_imm6;
    decode_t         w_dec;

    logic [W-1:0]    w_ra_data;
    logic [W-1:0]    w_rb_data;

    logic [NREG-1:0] w_wb_clear;
    logic [NREG-1:0] w_set;
    logic            w_rs_busy;
    logic            w_rt_busy;
    logic            w_rd_busy;
    logic            w_hazard;
    logic            w_in_ready;
    logic            w_accept;

    logic [NREG-1:0] r_pending;
    logic            r_out_valid;
    logic [W-1:0]    r_alu_a;
    logic [W-1:0]    r_alu_b;
    logic [2:0]      r_alu_op;
    logic [AW-1:0]   r_rd_out;
    logic            r_we_out;
    logic            r_illegal;

    assign w_opcode = io_bus.in_instr[OPC_MSB:OPC_LSB];
    assign w_rd     = io_bus.in_instr[RD_MSB:RD_LSB];
    assign w_rs     = io_bus.in_instr[RS_MSB:RS_LSB];
    assign w_rt     = io_bus.in_instr[RT_MSB:RT_LSB];
    assign w_imm6   = io_bus.in_instr[IMM_MSB:IMM_LSB];

    regfile_2r1w u_regfile (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_ra_addr (w_rs),
        .i_rb_addr (w_rt),
        .o_ra_data (w_ra_data),
        .o_rb_data (w_rb_data),
        .i_wb_en   (io_bus.wb_en),
        .i_wb_addr (io_bus.wb_addr),
        .i_wb_data (io_bus.wb_data)
    );

    // Opcode decode; unknown opcodes still issue, flagged illegal with no write-back.
    always_comb begin
        w_dec = '{op: ALU_NOP, we: 1'b0, illegal: 1'b0, use_imm: 1'b0, use_rt: 1'b0};
        case (w_opcode)
            OPC_NOP:  w_dec.op = ALU_NOP;
            OPC_ADD:  w_dec = '{op: ALU_ADD, we: 1'b1, illegal: 1'b0, use_imm: 1'b0, use_rt: 1'b1};
            OPC_SUB:  w_dec = '{op: ALU_SUB, we: 1'b1, illegal: 1'b0, use_imm: 1'b0, use_rt: 1'b1};
            OPC_SGE:  w_dec = '{op: ALU_SGE, we: 1'b1, illegal: 1'b0, use_imm: 1'b0, use_rt: 1'b1};
            OPC_ADDI: w_dec = '{op: ALU_ADD, we: 1'b1, illegal: 1'b0, use_imm: 1'b1, use_rt: 1'b0};
            default:  w_dec.illegal = 1'b1;
        endcase
    end

    // Per-register clear from write-back and set from an accepted writing instruction.
    always_comb begin
        w_wb_clear = '0;
        w_set      = '0;
        if (io_bus.wb_en) begin
            w_wb_clear[io_bus.wb_addr] = 1'b1;
        end
        if (w_accept && w_dec.we && (w_rd != '0)) begin
            w_set[w_rd] = 1'b1;
        end
    end

    // A source whose write-back lands this cycle is not a hazard: the bypass supplies it.
    assign w_rs_busy  = (w_rs != '0) && r_pending[w_rs] && !w_wb_clear[w_rs];
    assign w_rt_busy  = w_dec.use_rt && (w_rt != '0) && r_pending[w_rt] && !w_wb_clear[w_rt];
    assign w_rd_busy  = w_dec.we && r_pending[w_rd];
    assign w_hazard   = io_bus.in_valid && (w_rs_busy || w_rt_busy || w_rd_busy);
    assign w_in_ready = !w_hazard && (!r_out_valid || io_bus.out_ready);
    assign w_accept   = io_bus.in_valid && w_in_ready;

    // Scoreboard update; the set term is ORed last so it wins over a same-index clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_wb_clear) | w_set;
        end
    end

    // Issue bundle register: load on accept, drop valid when drained, hold under backpressure.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= ALU_NOP;
            r_rd_out    <= '0;
            r_we_out    <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_alu_a     <= w_ra_data;
            r_alu_b     <= w_dec.use_imm ? sext_imm6(w_imm6) : w_rb_data;
            r_alu_op    <= w_dec.op;
            r_rd_out    <= w_rd;
            r_we_out    <= w_dec.we;
            r_illegal   <= w_dec.illegal;
        end else if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.alu_a     = r_alu_a;
    assign io_bus.alu_b     = r_alu_b;
    assign io_bus.alu_op    = r_alu_op;
    assign io_bus.rd_out    = r_rd_out;
    assign io_bus.we_out    = r_we_out;
    assign io_bus.illegal   = r_illegal;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - scoreboard bench for the operand fetch issue stage
module tb_operand_fetch;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [2:0]  rd;
        logic        we;
        logic        ill;
    } bundle_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    int      n_tests = 0;
    int      n_fail  = 0;
    bundle_t exp_q[$];
    int      waits;

    operand_fetch_if bus ();

    operand_fetch dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic bundle_t mk(input logic [15:0] a, input logic [15:0] b,
                                   input logic [2:0] op, input logic [2:0] rd,
                                   input logic we, input logic ill);
        return '{a: a, b: b, op: op, rd: rd, we: we, ill: ill};
    endfunction

    // Monitor: every transferred bundle is compared against the oldest expectation.
    always @(negedge clk) begin
        bundle_t act;
        bundle_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            act = '{a: bus.alu_a, b: bus.alu_b, op: bus.alu_op, rd: bus.rd_out,
                    we: bus.we_out, ill: bus.illegal};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL bundle_unexpected actual a=%h b=%h op=%0d rd=%0d we=%0b ill=%0b required none",
                         act.a, act.b, act.op, act.rd, act.we, act.ill);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL bundle actual a=%h b=%h op=%0d rd=%0d we=%0b ill=%0b required a=%h b=%h op=%0d rd=%0d we=%0b ill=%0b",
                             act.a, act.b, act.op, act.rd, act.we, act.ill,
                             e.a, e.b, e.op, e.rd, e.we, e.ill);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [2:0] addr, input logic [15:0] data);
        bus.wb_en   = 1'b1;
        bus.wb_addr = addr;
        bus.wb_data = data;
        step();
        bus.wb_en   = 1'b0;
    endtask

    // Present an instruction until accepted; the expectation is queued at the accepting cycle.
    task automatic send(input logic [15:0] instr, input bundle_t e, output int nwait);
        bit ok;
        ok    = 1'b0;
        nwait = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                exp_q.push_back(e);
            end else begin
                nwait++;
                step();
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout instr=%h actual=stalled required=accepted", instr);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.wb_en     = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        step();
        step();
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_alu_a",     32'(bus.alu_a),     32'd0);
        check("rst_alu_b",     32'(bus.alu_b),     32'd0);
        check("rst_alu_op",    32'(bus.alu_op),    32'd0);
        check("rst_rd_we_ill", {29'd0, bus.rd_out} | 32'({bus.we_out, bus.illegal}), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;

        // Seed R1=5, R2=3, then ADD r3 <- r1, r2
        wb(3'd1, 16'h0005);
        wb(3'd2, 16'h0003);
        send(16'h1650, mk(16'h0005, 16'h0003, 3'b001, 3'd3, 1'b1, 1'b0), waits);
        @(negedge clk);
        check("add_latency_valid", 32'(bus.out_valid), 32'd1);
        step();

        // ADDI r1 <- r0 + sext(0x3F)
        send(16'h423F, mk(16'h0000, 16'hFFFF, 3'b001, 3'd1, 1'b1, 1'b0), waits);
        wb(3'd1, 16'h0005);
        wb(3'd3, 16'h0008);

        // RAW: ADD r3 <- r1, r2 then SUB r4 <- r3, r1 waits for the r3 write-back
        send(16'h1650, mk(16'h0005, 16'h0003, 3'b001, 3'd3, 1'b1, 1'b0), waits);
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h28C8;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("raw_stall_in_ready", 32'(bus.in_ready), 32'd0);
            step();
        end
        bus.wb_en   = 1'b1;
        bus.wb_addr = 3'd3;
        bus.wb_data = 16'h0042;
        @(negedge clk);
        check("raw_release_in_ready", 32'(bus.in_ready), 32'd1);
        if (bus.in_ready) exp_q.push_back(mk(16'h0042, 16'h0005, 3'b010, 3'd4, 1'b1, 1'b0));
        step();
        bus.wb_en    = 1'b0;
        bus.in_valid = 1'b0;
        wb(3'd4, 16'h0001);

        // Backpressure: bundle for r5 held for 3 cycles while r6 waits
        bus.out_ready = 1'b0;
        send(16'h1A50, mk(16'h0005, 16'h0003, 3'b001, 3'd5, 1'b1, 1'b0), waits);
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h1C50;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold",      {13'd0, bus.rd_out, bus.alu_a}, {13'd0, 3'd5, 16'h0005});
            step();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        if (bus.in_ready) exp_q.push_back(mk(16'h0005, 16'h0003, 3'b001, 3'd6, 1'b1, 1'b0));
        step();
        bus.in_valid = 1'b0;
        wb(3'd5, 16'h0010);
        wb(3'd6, 16'h0011);

        // Illegal opcode 0xF alongside a write-back to R0, then read R0 under the same write
        bus.wb_en   = 1'b1;
        bus.wb_addr = 3'd0;
        bus.wb_data = 16'hBEEF;
        send(16'hFE50, mk(16'h0005, 16'h0003, 3'b000, 3'd7, 1'b0, 1'b1), waits);
        send(16'h1E00, mk(16'h0000, 16'h0000, 3'b001, 3'd7, 1'b1, 1'b0), waits);
        bus.wb_en = 1'b0;
        wb(3'd7, 16'h0000);

        // Reset while a bundle is held and r3 is pending
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 16'h1650;
        @(negedge clk);
        check("mid_rst_pre_accept", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_held_valid", 32'(bus.out_valid), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        step();
        bus.out_ready = 1'b1;
        send(16'h28C8, mk(16'h0000, 16'h0000, 3'b010, 3'd4, 1'b1, 1'b0), waits);
        check("mid_rst_no_stall", 32'(waits), 32'd0);

        repeat (3) step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
